// File: rtl/alu_issue_stage_if.sv
// Issue-side bundle for the ALU issue stage: upstream entry, write-back forward
// path and the registered ALU-facing entry with its valid/ready handshake.
interface alu_issue_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 8
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [REG_AW-1:0] in_rs_addr;
    logic [DATA_W-1:0] in_rs_data;
    logic [REG_AW-1:0] in_rt_addr;
    logic [DATA_W-1:0] in_rt_data;
    logic [REG_AW-1:0] in_rd_addr;
    logic [IMM_W-1:0]  in_imm;
    logic              in_use_imm;
    logic              fwd_en;
    logic [REG_AW-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_ainvert;
    logic              out_binvert;
    logic              out_cin;
    logic [2:0]        out_operation;
    logic [REG_AW-1:0] out_rd_addr;
    logic              out_illegal;

    modport master (
        output flush, in_valid, in_op, in_rs_addr, in_rs_data, in_rt_addr,
               in_rt_data, in_rd_addr, in_imm, in_use_imm,
               fwd_en, fwd_addr, fwd_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_ainvert, out_binvert,
               out_cin, out_operation, out_rd_addr, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_op, in_rs_addr, in_rs_data, in_rt_addr,
               in_rt_data, in_rd_addr, in_imm, in_use_imm,
               fwd_en, fwd_addr, fwd_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_ainvert, out_binvert,
               out_cin, out_operation, out_rd_addr, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand read with write-back forwarding, immediate select,
// opcode decode into 1-bit-slice controls, single-entry output register.
module alu_issue_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 8
) (
    input logic               clk,
    input logic               rst,
    alu_issue_stage_if.slave  bus
);

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_NOR  = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTI = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRA  = 4'd9
    } op_e;

    typedef struct packed {
        logic       ainvert;
        logic       binvert;
        logic       cin;
        logic [2:0] operation;
        logic       illegal;
    } ctl_t;

    function automatic logic [DATA_W-1:0] src_value(
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              fwd_en,
        input logic [REG_AW-1:0] fwd_addr,
        input logic [DATA_W-1:0] fwd_data
    );
        if (addr == '0)
            return '0;
        else if (fwd_en && fwd_addr == addr)
            return fwd_data;
        else
            return rf_data;
    endfunction

    ctl_t              ctl;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              imm_sel;
    logic              shift_op;
    logic              accept;

    ctl_t              ctl_q;
    logic              valid_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [REG_AW-1:0] rd_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ctl = '0;
        unique case (bus.in_op)
            OP_AND:  ctl.operation = 3'b000;
            OP_OR:   ctl.operation = 3'b010;
            OP_XOR:  ctl.operation = 3'b011;
            OP_NOR:  begin ctl.ainvert = 1'b1; ctl.binvert = 1'b1; ctl.operation = 3'b000; end
            OP_ADD:  ctl.operation = 3'b100;
            OP_SUB:  begin ctl.binvert = 1'b1; ctl.cin = 1'b1; ctl.operation = 3'b100; end
            OP_SLT:  begin ctl.binvert = 1'b1; ctl.cin = 1'b1; ctl.operation = 3'b101; end
            OP_SLTI: ctl.operation = 3'b001;
            OP_SLL:  ctl.operation = 3'b110;
            OP_SRA:  ctl.operation = 3'b111;
            default: ctl.illegal = 1'b1;
        endcase
    end

    // Shift amounts are a zero-extended 4-bit field, not a signed immediate.
    assign shift_op = (bus.in_op == OP_SLL) || (bus.in_op == OP_SRA);
    assign imm_sel  = bus.in_use_imm || (bus.in_op == OP_SLTI);

    always_comb begin
        opnd_a = src_value(bus.in_rs_addr, bus.in_rs_data, bus.fwd_en, bus.fwd_addr, bus.fwd_data);
        opnd_b = src_value(bus.in_rt_addr, bus.in_rt_data, bus.fwd_en, bus.fwd_addr, bus.fwd_data);
        if (imm_sel) begin
            if (shift_op)
                opnd_b = {{(DATA_W-4){1'b0}}, bus.in_imm[3:0]};
            else
                opnd_b = {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
        end
    end

    assign bus.in_ready = ~valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            ctl_q   <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            a_q     <= opnd_a;
            b_q     <= opnd_b;
            rd_q    <= bus.in_rd_addr;
            ctl_q   <= ctl;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.out_a         = a_q;
    assign bus.out_b         = b_q;
    assign bus.out_rd_addr   = rd_q;
    assign bus.out_ainvert   = ctl_q.ainvert;
    assign bus.out_binvert   = ctl_q.binvert;
    assign bus.out_cin       = ctl_q.cin;
    assign bus.out_operation = ctl_q.operation;
    assign bus.out_illegal   = ctl_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by
// randomized traffic compared against a rule-level reference model.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_issue_stage_if #(.DATA_W(16), .REG_AW(3), .IMM_W(8)) bus ();

    alu_issue_stage #(.DATA_W(16), .REG_AW(3), .IMM_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ainv;
        logic        binv;
        logic        cin;
        logic [2:0]  oper;
        logic [2:0]  rd;
        logic        ill;
    } exp_t;

    // {ainvert, binvert, cin, operation} for opcodes 0..15
    localparam logic [5:0] CTL_TBL [16] = '{
        6'b000_000, 6'b000_010, 6'b000_011, 6'b110_000,
        6'b000_100, 6'b011_100, 6'b011_101, 6'b000_001,
        6'b000_110, 6'b000_111, 6'b000_000, 6'b000_000,
        6'b000_000, 6'b000_000, 6'b000_000, 6'b000_000
    };

    exp_t m;
    logic m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] read_src(input int addr, input logic [15:0] rf);
        if (addr == 0) return 16'h0000;
        if (bus.fwd_en && int'(bus.fwd_addr) == addr) return bus.fwd_data;
        return rf;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int op;
        int iv;
        logic [5:0] c;
        op = int'(bus.in_op);
        c  = CTL_TBL[op];
        e.ainv = c[5];
        e.binv = c[4];
        e.cin  = c[3];
        e.oper = c[2:0];
        e.ill  = (op >= 10);
        e.rd   = bus.in_rd_addr;
        e.a    = read_src(int'(bus.in_rs_addr), bus.in_rs_data);
        if (bus.in_use_imm || op == 7) begin
            iv = int'(bus.in_imm);
            if (op == 8 || op == 9) iv = iv % 16;
            else if (iv >= 128) iv = iv - 256;
            e.b = 16'(iv);
        end else begin
            e.b = read_src(int'(bus.in_rt_addr), bus.in_rt_data);
        end
        return e;
    endfunction

    task automatic check_outputs();
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_a", 32'(bus.out_a), 32'(m.a));
            check("out_b", 32'(bus.out_b), 32'(m.b));
            check("out_ainvert", 32'(bus.out_ainvert), 32'(m.ainv));
            check("out_binvert", 32'(bus.out_binvert), 32'(m.binv));
            check("out_cin", 32'(bus.out_cin), 32'(m.cin));
            check("out_operation", 32'(bus.out_operation), 32'(m.oper));
            check("out_rd_addr", 32'(bus.out_rd_addr), 32'(m.rd));
            check("out_illegal", 32'(bus.out_illegal), 32'(m.ill));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_a"}, 32'(bus.out_a), 32'd0);
        check({tag, "_b"}, 32'(bus.out_b), 32'd0);
        check({tag, "_ctl"}, 32'({bus.out_ainvert, bus.out_binvert, bus.out_cin, bus.out_operation}), 32'd0);
        check({tag, "_rd"}, 32'(bus.out_rd_addr), 32'd0);
        check({tag, "_illegal"}, 32'(bus.out_illegal), 32'd0);
    endtask

    // Settle inputs, check in_ready, advance the model, clock once, compare outputs.
    task automatic cycle();
        logic acc;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
        acc = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
        if (bus.flush) m_valid = 1'b0;
        else if (acc) begin m_valid = 1'b1; m = predict(); end
        else if (bus.out_ready) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_entry(input logic [3:0] op, input logic [2:0] rs, input logic [15:0] rs_d,
                             input logic [2:0] rt, input logic [15:0] rt_d, input logic [2:0] rd,
                             input logic [7:0] imm, input logic use_imm);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_rs_addr = rs;
        bus.in_rs_data = rs_d;
        bus.in_rt_addr = rt;
        bus.in_rt_data = rt_d;
        bus.in_rd_addr = rd;
        bus.in_imm     = imm;
        bus.in_use_imm = use_imm;
    endtask

    initial begin
        m_valid = 1'b0;
        m = '{default: '0};
        bus.flush = 0; bus.in_valid = 0; bus.in_op = 0; bus.in_rs_addr = 0; bus.in_rs_data = 0;
        bus.in_rt_addr = 0; bus.in_rt_data = 0; bus.in_rd_addr = 0; bus.in_imm = 0; bus.in_use_imm = 0;
        bus.fwd_en = 0; bus.fwd_addr = 0; bus.fwd_data = 0; bus.out_ready = 0;

        #2;
        check_all_zero("reset");
        #10;
        rst = 1'b0;

        // SUB r1,r2
        bus.out_ready = 1'b1;
        set_entry(4'd5, 3'd1, 16'h0005, 3'd2, 16'h0003, 3'd4, 8'h00, 1'b0);
        cycle();
        check("sub_a", 32'(bus.out_a), 32'h0005);
        check("sub_b", 32'(bus.out_b), 32'h0003);
        check("sub_ctl", 32'({bus.out_binvert, bus.out_cin, bus.out_operation}), 32'b11_100);

        // Immediates: sign-extended for ADD, zero-extended nibble for SLL
        set_entry(4'd4, 3'd1, 16'h0010, 3'd2, 16'h7777, 3'd5, 8'hFE, 1'b1);
        cycle();
        check("addi_b", 32'(bus.out_b), 32'hFFFE);
        set_entry(4'd8, 3'd1, 16'h0010, 3'd2, 16'h7777, 3'd5, 8'hF3, 1'b1);
        cycle();
        check("sll_b", 32'(bus.out_b), 32'h0003);
        check("sll_op", 32'(bus.out_operation), 32'b110);

        // Forwarding, and r0 immune to forwarding
        bus.fwd_en = 1'b1; bus.fwd_addr = 3'd3; bus.fwd_data = 16'h1234;
        set_entry(4'd4, 3'd3, 16'hAAAA, 3'd2, 16'h0001, 3'd6, 8'h00, 1'b0);
        cycle();
        check("fwd_a", 32'(bus.out_a), 32'h1234);
        bus.fwd_addr = 3'd0;
        set_entry(4'd4, 3'd0, 16'hAAAA, 3'd2, 16'h0001, 3'd6, 8'h00, 1'b0);
        cycle();
        check("fwd_r0_a", 32'(bus.out_a), 32'h0000);
        bus.fwd_en = 1'b0;

        // Backpressure: held for 3 cycles, then replaced on the same edge
        bus.out_ready = 1'b0;
        set_entry(4'd2, 3'd7, 16'h5A5A, 3'd6, 16'h0F0F, 3'd1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold_a", 32'(bus.out_a), 32'h0000);
        end
        bus.out_ready = 1'b1;
        cycle();
        check("bp_reload_valid", 32'(bus.out_valid), 32'd1);
        check("bp_reload_a", 32'(bus.out_a), 32'h5A5A);

        // Flush beats both accept and out_ready
        bus.flush = 1'b1;
        set_entry(4'd0, 3'd1, 16'hFFFF, 3'd1, 16'hFFFF, 3'd2, 8'h00, 1'b0);
        cycle();
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0;

        // Illegal opcode still passes downstream
        set_entry(4'd12, 3'd1, 16'h0042, 3'd2, 16'h0024, 3'd3, 8'h00, 1'b0);
        cycle();
        check("illegal_flag", 32'(bus.out_illegal), 32'd1);
        check("illegal_op", 32'(bus.out_operation), 32'd0);

        // Asynchronous reset mid-stream, between edges
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        rst = 1'b0;
        m_valid = 1'b0;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            bus.flush      = ($urandom_range(0, 15) == 0);
            bus.in_op      = 4'($urandom_range(0, 15));
            bus.in_rs_addr = 3'($urandom_range(0, 7));
            bus.in_rt_addr = 3'($urandom_range(0, 7));
            bus.in_rd_addr = 3'($urandom_range(0, 7));
            bus.in_rs_data = 16'($urandom);
            bus.in_rt_data = 16'($urandom);
            bus.in_imm     = 8'($urandom);
            bus.in_use_imm = ($urandom_range(0, 2) == 0);
            bus.fwd_en     = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 2))
                0: bus.fwd_addr = bus.in_rs_addr;
                1: bus.fwd_addr = bus.in_rt_addr;
                default: bus.fwd_addr = 3'($urandom_range(0, 7));
            endcase
            bus.fwd_data   = 16'($urandom);
            cycle();
        end

        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        check("drain_valid", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the 16-bit ALU (array of 1-bit ALU slices plus the 8:1 result mux).
- Latches register-file operands, applies write-back forwarding, selects the sign-extended immediate, and decodes a 4-bit ALU opcode into the slice controls (AInvert, BInvert, CIN, Operation).
- Single-entry registered output with a valid/ready handshake and a flush, so the ALU sees stable operands and controls for a full cycle.

Parameters:
- DATA_W, 16, operand width.
- REG_AW, 3, register address width (8 registers; r0 reads as zero).
- IMM_W, 8, raw immediate width before sign extension.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- flush  in  1  drop the held entry and any entry offered in the same cycle.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  4  ALU opcode (table below).
- in_rs_addr  in  REG_AW  source A register.
- in_rs_data  in  DATA_W  register-file read A.
- in_rt_addr  in  REG_AW  source B register.
- in_rt_data  in  DATA_W  register-file read B.
- in_rd_addr  in  REG_AW  destination register, passed through.
- in_imm  in  IMM_W  immediate.
- in_use_imm  in  1  B operand = immediate.
- fwd_en  in  1  write-back result valid this cycle.
- fwd_addr  in  REG_AW  write-back destination.
- fwd_data  in  DATA_W  write-back value.
- out_valid  out  1  held entry valid.
- out_ready  in  1  ALU consumes the entry this cycle.
- out_a, out_b  out  DATA_W  operands to ALU.
- out_ainvert, out_binvert, out_cin  out  1  slice controls (out_cin drives bit-0 CIN).
- out_operation  out  3  result mux select.
- out_rd_addr  out  REG_AW  destination.
- out_illegal  out  1  opcode 10-15 was captured.

Behaviour:
- Reset (async, active-high): out_valid=0; all data and control outputs 0. On deassertion, accepts on the first clock edge.
- in_ready = ~out_valid | out_ready, combinational; does not depend on in_valid.
- Accept = in_valid & in_ready & ~flush. On accept, every output register loads at the clock edge. Latency is 1 cycle from accept to out_valid.
- If out_valid & out_ready & no accept: out_valid goes to 0. If out_valid & ~out_ready: all outputs hold.
- flush: out_valid goes to 0 next edge. Flush has priority over both accept and out_ready.
- Operand A:
  - 0 if in_rs_addr==0.
  - Otherwise fwd_data if fwd_en and fwd_addr==in_rs_addr.
  - Otherwise in_rs_data.
- Operand B:
  - If in_use_imm: sign-extended in_imm. SLL and SRA instead use zero-extended in_imm[3:0].
  - Otherwise rt, with the same zero and forward rules as A.
- Forwarding is sampled only in the accept cycle. A held entry is never re-forwarded.
- Opcode decode, given as ainvert, binvert, cin, operation:
  - 0 AND 0,0,0,000
  - 1 OR 0,0,0,010
  - 2 XOR 0,0,0,011
  - 3 NOR 1,1,0,000
  - 4 ADD 0,0,0,100
  - 5 SUB 0,1,1,100
  - 6 SLT 0,1,1,101
  - 7 SLTI 0,0,0,001, B forced to the immediate regardless of in_use_imm
  - 8 SLL 0,0,0,110
  - 9 SRA 0,0,0,111
  - 10-15: controls 0,0,0,000 with out_illegal=1. The entry is still passed downstream.
- The ALU is not pipelined internally. The stage never issues two entries without an intervening out_ready cycle.

Test Plan:
- Reset mid-stream with out_valid=1, Reset pulsed between edges -> out_valid=0 and all outputs 0 immediately, before any clock edge.
- SUB r1,r2 with rs_data=0x0005, rt_data=0x0003 -> next cycle out_a=0x0005, out_b=0x0003, binvert=1, cin=1, operation=100.
- ADD with in_use_imm=1, in_imm=0xFE -> out_b=0xFFFE; SLL with in_imm=0xF3 -> out_b=0x0003, operation=110.
- Forward: in_rs_addr=3, fwd_en=1, fwd_addr=3, fwd_data=0x1234, rs_data=0xAAAA -> out_a=0x1234. Same with in_rs_addr=0 and fwd_addr=0 -> out_a=0x0000.
- Backpressure: entry held with out_ready=0 for 3 cycles -> in_ready=0 and outputs stable. Raise out_ready with in_valid=1 -> new entry loaded the same edge and out_valid stays 1.
- flush with in_valid=1 and out_ready=1 on a held entry -> out_valid=0 next cycle, new entry dropped. Opcode 12 -> out_illegal=1, operation=000.
